// File: rtl/mc_amm_req_issuer_pkg.sv
// Shared widths and response types for the EMIF Avalon-MM request issuer.
package mc_amm_pkg;

    localparam int AMM_ADDR_W  = 28;
    localparam int AMM_DATA_W  = 576;
    localparam int AMM_BURST_W = 7;
    localparam int AMM_TAG_W   = 8;

    typedef logic [AMM_TAG_W-1:0] tag_t;

    typedef struct packed {
        tag_t                  tag;
        logic [AMM_DATA_W-1:0] data;
    } rsp_t;

    // Width of a counter able to hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mc_amm_req_issuer_if.sv
// Request, AMM command/read-return and read-response bundles for the issuer.
interface mc_amm_req_if
    import mc_amm_pkg::*;
#(
    parameter int ADDR_W = AMM_ADDR_W,
    parameter int DATA_W = AMM_DATA_W,
    parameter int TAG_W  = AMM_TAG_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [TAG_W-1:0]  req_tag;

    modport master (output req_valid, req_write, req_addr, req_wdata, req_tag,
                    input  req_ready);
    modport slave  (input  req_valid, req_write, req_addr, req_wdata, req_tag,
                    output req_ready);
endinterface

interface mc_amm_bus_if
    import mc_amm_pkg::*;
#(
    parameter int ADDR_W = AMM_ADDR_W,
    parameter int DATA_W = AMM_DATA_W
);
    logic                   amm_read;
    logic                   amm_write;
    logic [ADDR_W-1:0]      amm_address;
    logic [DATA_W-1:0]      amm_writedata;
    logic [AMM_BURST_W-1:0] amm_burstcount;
    logic                   amm_ready;
    logic [DATA_W-1:0]      amm_readdata;
    logic                   amm_readdatavalid;

    modport master (output amm_read, amm_write, amm_address, amm_writedata, amm_burstcount,
                    input  amm_ready, amm_readdata, amm_readdatavalid);
    modport slave  (input  amm_read, amm_write, amm_address, amm_writedata, amm_burstcount,
                    output amm_ready, amm_readdata, amm_readdatavalid);
endinterface

interface mc_amm_rsp_if
    import mc_amm_pkg::*;
#(
    parameter int DATA_W = AMM_DATA_W,
    parameter int TAG_W  = AMM_TAG_W
);
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (output rsp_valid, rsp_data, rsp_tag, input  rsp_ready);
    modport slave  (input  rsp_valid, rsp_data, rsp_tag, output rsp_ready);
endinterface

// File: rtl/mc_amm_req_issuer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
module mc_amm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/mc_amm_req_issuer.sv
// Issues single-beat requests to the EMIF AMM port, bounds outstanding reads with
// credits and returns tagged read data in order.
module mc_amm_req_issuer
    import mc_amm_pkg::*;
#(
    parameter int ADDR_W          = AMM_ADDR_W,
    parameter int DATA_W          = AMM_DATA_W,
    parameter int TAG_W           = AMM_TAG_W,
    parameter int MAX_OUTSTANDING = 16,
    parameter int RSP_DEPTH       = 16,
    localparam int CNT_W          = cnt_width(MAX_OUTSTANDING)
) (
    input  logic             emif_usr_clk,
    input  logic             emif_usr_rst,
    input  logic             local_cal_success,
    mc_amm_req_if.slave      req,
    mc_amm_bus_if.master     amm,
    mc_amm_rsp_if.master     rsp,
    output logic [CNT_W-1:0] rd_outstanding,
    output logic             err_unexpected_rd
);

    if (RSP_DEPTH < MAX_OUTSTANDING) begin : g_rsp_depth_chk
        $error("RSP_DEPTH must be >= MAX_OUTSTANDING");
    end
    if ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_max_out_chk
        $error("MAX_OUTSTANDING must be a power of 2");
    end

    logic              cal_ok;
    logic              cmd_vld_p1;
    logic              cmd_write_p1;
    logic [ADDR_W-1:0] cmd_addr_p1;
    logic [DATA_W-1:0] cmd_wdata_p1;

    logic              cmd_accept;
    logic              credit_avail;
    logic              req_fire;
    logic              rd_issue;

    logic              tag_pop;
    logic [TAG_W-1:0]  tag_head;
    logic              tag_full;
    logic              tag_empty;

    logic              rsp_push;
    logic              rsp_pop;
    logic              rsp_full;
    logic              rsp_empty;
    logic [TAG_W+DATA_W-1:0] rsp_head;

    // Request acceptance: the command slot must be free or draining this cycle.
    assign cmd_accept   = cmd_vld_p1 & amm.amm_ready;
    assign credit_avail = rd_outstanding < CNT_W'(MAX_OUTSTANDING);
    assign req.req_ready = cal_ok & (~cmd_vld_p1 | cmd_accept) & (req.req_write | credit_avail);
    assign req_fire     = req.req_valid & req.req_ready;
    assign rd_issue     = req_fire & ~req.req_write;

    always_ff @(posedge emif_usr_clk or posedge emif_usr_rst) begin
        if (emif_usr_rst) begin
            cal_ok <= 1'b0;
        end else begin
            cal_ok <= local_cal_success;
        end
    end

    // Stage p1: command register presented on the AMM bus
    always_ff @(posedge emif_usr_clk or posedge emif_usr_rst) begin
        if (emif_usr_rst) begin
            cmd_vld_p1   <= 1'b0;
            cmd_write_p1 <= 1'b0;
            cmd_addr_p1  <= '0;
            cmd_wdata_p1 <= '0;
        end else if (req_fire) begin
            cmd_vld_p1   <= 1'b1;
            cmd_write_p1 <= req.req_write;
            cmd_addr_p1  <= req.req_addr;
            cmd_wdata_p1 <= req.req_wdata;
        end else if (cmd_accept) begin
            cmd_vld_p1   <= 1'b0;
        end
    end

    assign amm.amm_read       = cmd_vld_p1 & ~cmd_write_p1;
    assign amm.amm_write      = cmd_vld_p1 & cmd_write_p1;
    assign amm.amm_address    = cmd_addr_p1;
    assign amm.amm_writedata  = cmd_wdata_p1;
    assign amm.amm_burstcount = AMM_BURST_W'(1);

    // Read return: data without a waiting tag is dropped and flagged.
    assign tag_pop  = amm.amm_readdatavalid & ~tag_empty;
    assign rsp_push = tag_pop;
    assign rsp_pop  = ~rsp_empty & rsp.rsp_ready;

    mc_amm_sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (emif_usr_clk),
        .rst   (emif_usr_rst),
        .push  (rd_issue),
        .din   (req.req_tag),
        .pop   (tag_pop),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    mc_amm_sync_fifo #(
        .WIDTH (TAG_W + DATA_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (emif_usr_clk),
        .rst   (emif_usr_rst),
        .push  (rsp_push),
        .din   ({tag_head, amm.amm_readdata}),
        .pop   (rsp_pop),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty)
    );

    assign rsp.rsp_valid = ~rsp_empty;
    assign {rsp.rsp_tag, rsp.rsp_data} = rsp_head;

    // Credits return only when the consumer pops, so the response buffer cannot overflow.
    always_ff @(posedge emif_usr_clk or posedge emif_usr_rst) begin
        if (emif_usr_rst) begin
            rd_outstanding    <= '0;
            err_unexpected_rd <= 1'b0;
        end else begin
            case ({rd_issue, rsp_pop})
                2'b10:   rd_outstanding <= rd_outstanding + 1'b1;
                2'b01:   rd_outstanding <= rd_outstanding - 1'b1;
                default: ;
            endcase
            if (amm.amm_readdatavalid & tag_empty) err_unexpected_rd <= 1'b1;
        end
    end

    a_rsp_no_overflow : assert property (@(posedge emif_usr_clk) disable iff (emif_usr_rst)
        !(rsp_push && rsp_full));
    a_tag_no_overflow : assert property (@(posedge emif_usr_clk) disable iff (emif_usr_rst)
        !(rd_issue && tag_full && !tag_pop));

endmodule
